// File: rtl/fifo_pkg.sv
// Shared helpers and types for the parametrised sync FIFO.
package fifo_pkg;

   typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_UNF} err_cause_e;

   function automatic int clog2_f(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, synchronous write, registered read with resettable output.
// With FIFO_SUM_EN an extra asynchronous peek port exposes the word at raddr.
module fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
`ifdef FIFO_SUM_EN
   ,
   output logic [WIDTH-1:0] peek
`endif
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset_n)  rdata <= '0;
      else if (re)   rdata <= mem[raddr];
   end

`ifdef FIFO_SUM_EN
   assign peek = mem[raddr];
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy flags, sticky errors and flush.
// Define FIFO_SUM_EN to build the running sum of stored entries; otherwise sum is 0.
module sync_fifo_param import fifo_pkg::*; #(
   parameter  int WIDTH     = 8,
   parameter  int DEPTH     = 16,
   localparam int AW        = clog2_f(DEPTH),
   parameter  int AF_THRESH = DEPTH - 2,
   parameter  int AE_THRESH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              wr,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              rd,
   input  logic              clr_err,
   output logic [WIDTH-1:0]  data_out,
   output logic              dout_valid,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [AW:0]       count,
   output logic              overflow,
   output logic              underflow,
   output logic [WIDTH+AW-1:0] sum
);

   generate
      if (!is_pow2(DEPTH) || !(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_cfg
         $error("sync_fifo_param: DEPTH must be a power of 2 and AE_THRESH < AF_THRESH <= DEPTH");
      end
   endgenerate

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

   logic [AW:0] waddr, raddr;
   logic        rd_acc, wr_acc, we, re, ovf_set, unf_set;

   assign empty        = (count == '0);
   assign full         = (count == DEPTH_C);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // A read frees a slot this cycle, so a full FIFO can still take a write.
   assign rd_acc  = rd & ~empty;
   assign wr_acc  = wr & (~full | rd_acc);
   assign we      = wr_acc & ~flush;
   assign re      = rd_acc & ~flush;
   assign ovf_set = wr & ~wr_acc;
   assign unf_set = rd & ~rd_acc;

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         waddr <= '0;
         raddr <= '0;
         count <= '0;
      end else begin
         if (we) waddr <= waddr + 1'b1;
         if (re) raddr <= raddr + 1'b1;
         unique case ({we, re})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) dout_valid <= 1'b0;
      else                   dout_valid <= re;
   end

   // A fresh error in the same cycle beats clr_err; flush leaves flags alone.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (!flush) begin
         overflow  <= ovf_set | (overflow  & ~clr_err);
         underflow <= unf_set | (underflow & ~clr_err);
      end
   end

`ifdef FIFO_SUM_EN
   logic [WIDTH-1:0]    peek;
   logic [WIDTH+AW-1:0] sum_q, add_v, sub_v;

   assign add_v = we ? {{AW{1'b0}}, data_in} : '0;
   assign sub_v = re ? {{AW{1'b0}}, peek}    : '0;

   always_ff @(posedge clk) begin
      if (!reset_n || flush) sum_q <= '0;
      else                   sum_q <= sum_q + add_v - sub_v;
   end

   assign sum = sum_q;
`else
   assign sum = '0;
`endif

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we),
      .waddr   (waddr[AW-1:0]),
      .wdata   (data_in),
      .re      (re),
      .raddr   (raddr[AW-1:0]),
      .rdata   (data_out)
`ifdef FIFO_SUM_EN
      ,
      .peek    (peek)
`endif
   );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=16); honours FIFO_SUM_EN.
module tb_sync_fifo_param;

   logic        clk = 1'b0, reset_n = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
   logic [7:0]  data_in = '0;
   logic [7:0]  data_out;
   logic        dout_valid, empty, full, almost_full, almost_empty, overflow, underflow;
   logic [4:0]  count;
   logic [11:0] sum;

   sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .wr(wr), .data_in(data_in), .rd(rd),
      .clr_err(clr_err), .data_out(data_out), .dout_valid(dout_valid), .empty(empty),
      .full(full), .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow), .sum(sum));

   always #5 clk = ~clk;

   int         n_vec = 0, n_fail = 0;
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   logic       m_ovf = 0, m_unf = 0, m_dv = 0;
   logic [7:0] m_dout = 0;
   bit         mon_en = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever a read result is due.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("dout_valid", {31'd0, dout_valid}, {31'd0, m_dv});
         if (m_dv) begin
            if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
            else                   chk("data_out_seq", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
      bit  racc, wacc;
      int  s;
      wr = w; data_in = d; rd = r; flush = f; clr_err = c;
      @(posedge clk); #1;
      if (!reset_n) begin
         mq.delete(); exp_q.delete();
         m_ovf = 0; m_unf = 0; m_dv = 0; m_dout = 0;
      end else if (f) begin
         mq.delete(); m_dv = 0;
      end else begin
         racc = r && (mq.size() != 0);
         wacc = w && ((mq.size() != 16) || racc);
         m_dv = racc;
         if (racc) begin
            m_dout = mq.pop_front();
            exp_q.push_back(m_dout);
         end
         if (wacc) mq.push_back(d);
         if (w && !wacc) m_ovf = 1; else if (c) m_ovf = 0;
         if (r && !racc) m_unf = 1; else if (c) m_unf = 0;
      end
      s = 0;
      foreach (mq[i]) s += int'(mq[i]);
      chk("count",        {27'd0, count},        mq.size());
      chk("empty",        {31'd0, empty},        (mq.size() == 0)  ? 1 : 0);
      chk("full",         {31'd0, full},         (mq.size() == 16) ? 1 : 0);
      chk("almost_full",  {31'd0, almost_full},  (mq.size() >= 14) ? 1 : 0);
      chk("almost_empty", {31'd0, almost_empty}, (mq.size() <= 2)  ? 1 : 0);
      chk("overflow",     {31'd0, overflow},     {31'd0, m_ovf});
      chk("underflow",    {31'd0, underflow},    {31'd0, m_unf});
      chk("data_out",     {24'd0, data_out},     {24'd0, m_dout});
`ifdef FIFO_SUM_EN
      chk("sum", {20'd0, sum}, s);
`else
      chk("sum", {20'd0, sum}, 0);
`endif
   endtask

   task automatic wrt(input logic [7:0] d); step(1, d, 0, 0, 0); endtask
   task automatic rdd();                    step(0, 8'h00, 1, 0, 0); endtask
   task automatic idle();                   step(0, 8'h00, 0, 0, 0); endtask

   initial begin
      // Reset state
      reset_n = 1'b0;
      idle();
      mon_en = 1;
      idle();
      chk("rst_data_out", {24'd0, data_out}, 0);
      chk("rst_count", {27'd0, count}, 0);
      reset_n = 1'b1;

      // 1: fill to full, then overflow
      for (int i = 0; i < 15; i++) wrt(8'h11 + 8'(i));
      chk("t1_count15", {27'd0, count}, 15);
      chk("t1_af", {31'd0, almost_full}, 1);
      chk("t1_not_full", {31'd0, full}, 0);
      wrt(8'h20);
      chk("t1_full", {31'd0, full}, 1);
      wrt(8'h21);
      chk("t1_overflow", {31'd0, overflow}, 1);
      chk("t1_count16", {27'd0, count}, 16);

      // 2: drain in order, then underflow with data_out held
      for (int i = 0; i < 16; i++) begin
         rdd();
         chk("t2_order", {24'd0, data_out}, 32'h11 + i);
      end
      chk("t2_empty", {31'd0, empty}, 1);
      rdd();
      chk("t2_underflow", {31'd0, underflow}, 1);
      chk("t2_hold", {24'd0, data_out}, 32'h20);
      step(0, 8'h00, 0, 0, 1);
      chk("t2_clr", {30'd0, overflow, underflow}, 0);

      // 3: full with simultaneous wr/rd across pointer wrap
      for (int i = 0; i < 16; i++) wrt(8'h30 + 8'(i));
      for (int i = 0; i < 40; i++) step(1, 8'h80 + 8'(i), 1, 0, 0);
      chk("t3_count", {27'd0, count}, 16);
      chk("t3_no_ovf", {31'd0, overflow}, 0);
      for (int i = 0; i < 16; i++) rdd();
      chk("t3_last", {24'd0, data_out}, 32'hA7);

      // 4: wr+rd on empty: no bypass
      step(1, 8'h5A, 1, 0, 0);
      chk("t4_unf", {31'd0, underflow}, 1);
      chk("t4_count", {27'd0, count}, 1);
      rdd();
      chk("t4_dout", {24'd0, data_out}, 32'h5A);
      step(0, 8'h00, 1, 0, 1);
      chk("t4_err_beats_clr", {31'd0, underflow}, 1);

      // 5: flush keeps error flags, clr_err clears them, then reset mid-burst
      for (int i = 0; i < 5; i++) wrt(8'h60 + 8'(i));
      step(1, 8'h99, 0, 1, 0);
      chk("t5_flush_count", {27'd0, count}, 0);
      chk("t5_flush_ovf", {31'd0, overflow}, 0);
      chk("t5_flush_unf_kept", {31'd0, underflow}, 1);
      chk("t5_flush_dout_kept", {24'd0, data_out}, 32'h5A);
      step(0, 8'h00, 0, 0, 1);
      chk("t5_clr", {31'd0, underflow}, 0);
      wrt(8'h71); wrt(8'h72); rdd();
      reset_n = 1'b0;
      step(1, 8'h73, 1, 0, 0);
      reset_n = 1'b1;
      chk("t5_rst_count", {27'd0, count}, 0);
      chk("t5_rst_dout", {24'd0, data_out}, 0);
      chk("t5_rst_dv", {31'd0, dout_valid}, 0);

      // 6: running sum
      wrt(8'd10); wrt(8'd20); wrt(8'd30);
`ifdef FIFO_SUM_EN
      chk("t6_sum60", {20'd0, sum}, 60);
`else
      chk("t6_sum0", {20'd0, sum}, 0);
`endif
      rdd();
`ifdef FIFO_SUM_EN
      chk("t6_sum50", {20'd0, sum}, 50);
`else
      chk("t6_sum0", {20'd0, sum}, 0);
`endif
      step(1, 8'd7, 1, 0, 0);
`ifdef FIFO_SUM_EN
      chk("t6_sum37", {20'd0, sum}, 37);
`else
      chk("t6_sum0", {20'd0, sum}, 0);
`endif
      rdd(); rdd(); rdd(); idle();
      @(negedge clk); #1;
      mon_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
